// File: rtl/cachepkg.sv
// cachepkg: responder FSM state type and latency bound shared by next_level_mem_responder
package cachepkg;
  typedef enum logic [1:0] {MR_IDLE, MR_WAIT, MR_RESP} memresp_state_t;
  localparam int MEMRESP_MAX_LATENCY = 255;
endpackage

// File: rtl/memresp_store.sv
// memresp_store: backing store with per-word valid bits, one write port and one async read port
module memresp_store #(
  parameter int WORD_W     = 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  we,
  input  logic [DEPTH_LOG2-1:0] waddr,
  input  logic [WORD_W-1:0]     wdata,
  input  logic [DEPTH_LOG2-1:0] raddr,
  output logic [WORD_W-1:0]     rdata,
  output logic                  rvalid
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  valid_q, valid_d;
  // a written word becomes valid
  always_comb begin
    valid_d = valid_q;
    if (we) valid_d[waddr] = 1'b1;
  end
  // valid bits clear on reset so every word reads as fill afterwards
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else valid_q <= valid_d;
  end
  // data array is never reset; the valid bit masks stale contents
  always_ff @(posedge clock) begin
    if (we) mem_q[waddr] <= wdata;
  end
  assign rdata  = mem_q[raddr];
  assign rvalid = valid_q[raddr];
endmodule

// File: rtl/next_level_mem_responder.sv
// next_level_mem_responder: single-outstanding next-level memory responder with fixed latency; NEXT_LEVEL_MEM_RESPONDER_STATS_EN adds stat counters
module next_level_mem_responder
  import cachepkg::*;
#(
  parameter int                WORD_W     = 8,
  parameter int                ADDR_W     = 32,
  parameter int                DEPTH_LOG2 = 8,
  parameter int                LATENCY    = 4,
  parameter logic [WORD_W-1:0] FILL_WORD  = WORD_W'(8'hA5)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_write,
  output logic [WORD_W-1:0] resp_rdata
`ifdef NEXT_LEVEL_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]       stat_reads,
  output logic [31:0]       stat_writes,
  output logic [31:0]       stat_stall
`endif
);
  localparam int CNT_W = $clog2(MEMRESP_MAX_LATENCY + 1);
  memresp_state_t        state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  wr_q, wr_d;
  logic [DEPTH_LOG2-1:0] addr_q, addr_d;
  logic [WORD_W-1:0]     wdata_q, wdata_d;
  logic                  resp_write_q, resp_write_d;
  logic [WORD_W-1:0]     resp_rdata_q, resp_rdata_d;
  logic                  idle, go_resp, eff_wr, st_rvalid, unused_addr;
  logic [DEPTH_LOG2-1:0] eff_addr;
  logic [WORD_W-1:0]     eff_wdata, st_rdata;
  assign idle        = state_q == MR_IDLE;
  assign req_ready   = idle;
  assign resp_valid  = state_q == MR_RESP;
  assign resp_write  = resp_write_q;
  assign resp_rdata  = resp_rdata_q;
  assign unused_addr = ^req_addr[ADDR_W-1:DEPTH_LOG2];
  // with LATENCY 1 the store is touched on the accept edge, before the capture regs hold the request
  assign eff_wr    = idle ? req_write : wr_q;
  assign eff_addr  = idle ? req_addr[DEPTH_LOG2-1:0] : addr_q;
  assign eff_wdata = idle ? req_wdata : wdata_q;
  memresp_store #(.WORD_W(WORD_W), .DEPTH_LOG2(DEPTH_LOG2)) u_store (
    .clock  (clock),
    .reset_n(reset_n),
    .we     (go_resp && eff_wr),
    .waddr  (eff_addr),
    .wdata  (eff_wdata),
    .raddr  (eff_addr),
    .rdata  (st_rdata),
    .rvalid (st_rvalid)
  );
  // next state, latency countdown, request capture and response sampling on entry to RESP
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_write_d = resp_write_q;
    resp_rdata_d = resp_rdata_q;
    go_resp      = 1'b0;
    case (state_q)
      MR_IDLE: if (req_valid) begin
        wr_d    = req_write;
        addr_d  = req_addr[DEPTH_LOG2-1:0];
        wdata_d = req_wdata;
        cnt_d   = CNT_W'(LATENCY - 1);
        go_resp = LATENCY == 1;
        state_d = MR_WAIT;
      end
      MR_WAIT: begin
        cnt_d   = cnt_q - 1'b1;
        go_resp = cnt_q == CNT_W'(1);
      end
      MR_RESP: state_d = resp_ready ? MR_IDLE : MR_RESP;
      default: state_d = MR_IDLE;
    endcase
    if (go_resp) begin
      state_d      = MR_RESP;
      resp_write_d = eff_wr;
      resp_rdata_d = eff_wr ? '0 : (st_rvalid ? st_rdata : FILL_WORD);
    end
  end
  // control and response registers; a pending request is simply dropped by reset
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= MR_IDLE;
      cnt_q        <= '0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_write_q <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_write_q <= resp_write_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end
`ifdef NEXT_LEVEL_MEM_RESPONDER_STATS_EN
  logic [31:0] stat_reads_q, stat_reads_d, stat_writes_q, stat_writes_d, stat_stall_q, stat_stall_d;
  logic        hs;
  assign hs          = resp_valid && resp_ready;
  assign stat_reads  = stat_reads_q;
  assign stat_writes = stat_writes_q;
  assign stat_stall  = stat_stall_q;
  // saturating event counters
  always_comb begin
    stat_reads_d  = (hs && !resp_write_q && stat_reads_q != '1) ? stat_reads_q + 32'd1 : stat_reads_q;
    stat_writes_d = (hs && resp_write_q && stat_writes_q != '1) ? stat_writes_q + 32'd1 : stat_writes_q;
    stat_stall_d  = (resp_valid && !resp_ready && stat_stall_q != '1) ? stat_stall_q + 32'd1 : stat_stall_q;
  end
  // counter registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_reads_q  <= '0;
      stat_writes_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_reads_q  <= stat_reads_d;
      stat_writes_q <= stat_writes_d;
      stat_stall_q  <= stat_stall_d;
    end
  end
`endif
endmodule

// File: tb/tb_next_level_mem_responder.sv
// tb_next_level_mem_responder: random and directed checks of two responders (LATENCY 4 and 1) against a transaction model
module tb_next_level_mem_responder;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic        reset_n [2], req_valid [2], req_write [2], resp_ready [2];
  logic        req_ready [2], resp_valid [2], resp_write [2];
  logic [31:0] req_addr [2];
  logic [7:0]  req_wdata [2], resp_rdata [2];
`ifdef NEXT_LEVEL_MEM_RESPONDER_STATS_EN
  logic [31:0] stat_reads [2], stat_writes [2], stat_stall [2];
`endif
  int total = 0, bad = 0;
  bit go = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int L = (g == 0) ? 4 : 1;
    next_level_mem_responder #(.LATENCY(L)) dut (
      .clock     (clock),
      .reset_n   (reset_n[g]),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .resp_valid(resp_valid[g]),
      .resp_ready(resp_ready[g]),
      .resp_write(resp_write[g]),
      .resp_rdata(resp_rdata[g])
`ifdef NEXT_LEVEL_MEM_RESPONDER_STATS_EN
      ,
      .stat_reads (stat_reads[g]),
      .stat_writes(stat_writes[g]),
      .stat_stall (stat_stall[g])
`endif
    );
    bit         busy, inresp, cw, erw;
    int         age, cidx, n_rd, n_wr, n_st;
    logic [7:0] cwd, erd;
    logic [7:0] mem [int];
    task commit;
      inresp = 1'b1;
      erw    = cw;
      if (cw) begin
        mem[cidx] = cwd;
        erd       = 8'h00;
      end else erd = mem.exists(cidx) ? mem[cidx] : 8'hA5;
    endtask
    always @(posedge clock or negedge reset_n[g]) begin
      if (!reset_n[g]) begin
        busy = 0; inresp = 0; mem.delete(); n_rd = 0; n_wr = 0; n_st = 0;
      end else if (!busy) begin
        if (req_valid[g]) begin
          busy = 1; age = 0; cw = req_write[g]; cidx = int'(req_addr[g] % 256); cwd = req_wdata[g];
          if (age == L - 1) commit();
        end
      end else if (!inresp) begin
        age++;
        if (age == L - 1) commit();
      end else if (resp_ready[g]) begin
        busy = 0; inresp = 0;
        if (erw) n_wr++; else n_rd++;
      end else n_st++;
    end
    always @(negedge clock) if (go) begin
      check($sformatf("req_ready[%0d]", g), req_ready[g], !busy);
      check($sformatf("resp_valid[%0d]", g), resp_valid[g], inresp);
      if (inresp) begin
        check($sformatf("resp_write[%0d]", g), resp_write[g], erw);
        check($sformatf("resp_rdata[%0d]", g), resp_rdata[g], erd);
      end
`ifdef NEXT_LEVEL_MEM_RESPONDER_STATS_EN
      check($sformatf("stat_reads[%0d]", g), stat_reads[g], n_rd);
      check($sformatf("stat_writes[%0d]", g), stat_writes[g], n_wr);
      check($sformatf("stat_stall[%0d]", g), stat_stall[g], n_st);
`endif
    end
  end

  task automatic txn(input int d, input bit w, input logic [31:0] a, input logic [7:0] wd, input int hold,
                     output logic [7:0] rd, output int lat, output logic rw);
    int t = 0;
    req_valid[d] = 1; req_write[d] = w; req_addr[d] = a; req_wdata[d] = wd; resp_ready[d] = (hold == 0);
    while (!req_ready[d] && t < 100) begin @(posedge clock); #1; t++; end
    check("accept_wait", req_ready[d], 1);
    @(posedge clock); #1;
    req_valid[d] = 0; req_write[d] = 1'($urandom); req_addr[d] = $urandom; req_wdata[d] = 8'($urandom);
    lat = 1;
    while (!resp_valid[d] && lat < 300) begin @(posedge clock); #1; lat++; end
    check("resp_seen", resp_valid[d], 1);
    rd = resp_rdata[d]; rw = resp_write[d];
    repeat (hold) begin
      req_valid[d] = 1; req_write[d] = 1'($urandom); req_addr[d] = $urandom;
      @(posedge clock); #1;
    end
    req_valid[d] = 0; resp_ready[d] = 1;
    @(posedge clock); #1;
    resp_ready[d] = 0;
  endtask

  task automatic rnd(input int d);
    logic [7:0] rd;
    logic rw;
    int lat;
    for (int n = 0; n < 120; n++) begin
      repeat ($urandom_range(0, 2)) begin @(posedge clock); #1; end
      txn(d, 1'($urandom), ($urandom & 32'hFFFF_FF00) | $urandom_range(0, 15), 8'($urandom),
          $urandom_range(0, 3), rd, lat, rw);
    end
  endtask

  initial begin
    logic [7:0] rd;
    logic rw;
    int lat, acc;
    for (int d = 0; d < 2; d++) begin
      reset_n[d] = 0; req_valid[d] = 0; req_write[d] = 0; req_addr[d] = 0; req_wdata[d] = 0; resp_ready[d] = 0;
    end
    repeat (3) @(posedge clock);
    #1;
    reset_n[0] = 1; reset_n[1] = 1; go = 1;
    for (int d = 0; d < 2; d++) begin
      check("rst_req_ready", req_ready[d], 1);
      check("rst_resp_valid", resp_valid[d], 0);
      check("rst_resp_write", resp_write[d], 0);
      check("rst_resp_rdata", resp_rdata[d], 0);
    end
    txn(0, 0, 32'h10, 8'h00, 0, rd, lat, rw);
    check("t1_lat", lat, 4); check("t1_rdata", rd, 8'hA5); check("t1_rw", rw, 0);
    txn(0, 1, 32'h10, 8'h3C, 0, rd, lat, rw);
    check("t2_wack_rw", rw, 1); check("t2_wack_rdata", rd, 8'h00);
    txn(0, 0, 32'h10, 8'h00, 0, rd, lat, rw);
    check("t2_rdata", rd, 8'h3C);
    txn(0, 1, 32'h0000_0105, 8'h77, 0, rd, lat, rw);
    txn(0, 0, 32'h0000_0005, 8'h00, 0, rd, lat, rw);
    check("t3_wrap", rd, 8'h77);
    txn(0, 0, 32'h10, 8'h00, 10, rd, lat, rw);
    check("t4_rdata", rd, 8'h3C);
`ifdef NEXT_LEVEL_MEM_RESPONDER_STATS_EN
    check("t4_stall", stat_stall[0], 10);
`endif
    acc = 0; resp_ready[1] = 1; req_valid[1] = 1; req_write[1] = 0;
    repeat (10) begin
      req_addr[1] = $urandom;
      @(negedge clock);
      if (req_valid[1] && req_ready[1]) acc++;
      @(posedge clock); #1;
    end
    req_valid[1] = 0; resp_ready[1] = 0;
    check("t5_accepts", acc, 5);
    txn(1, 0, 32'h44, 8'h00, 0, rd, lat, rw);
    check("t5_lat", lat, 1); check("t5_rdata", rd, 8'hA5);
    req_valid[0] = 1; req_write[0] = 1; req_addr[0] = 32'h20; req_wdata[0] = 8'h5A;
    @(posedge clock); #1;
    req_valid[0] = 0;
    @(posedge clock); #1;
    reset_n[0] = 0;
    #3 reset_n[0] = 1;
    check("t6_no_resp", resp_valid[0], 0);
    txn(0, 0, 32'h20, 8'h00, 0, rd, lat, rw);
    check("t6_dropped", rd, 8'hA5);
    fork
      rnd(0);
      rnd(1);
    join
    repeat (2) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
